// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM encoding and
// the idle/alignment comma shared with the parallel-to-serial transmitter.
package serial_paralelo_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage : serial_paralelo_pkg

// File: rtl/sp_shift_reg.sv
// Serial input shift register with a comma comparator on the next-state value,
// so the FSM sees the byte completed by the bit being sampled this cycle.
module sp_shift_reg
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] sr_next,
  output logic       is_comma
);

  logic [7:0] sr;

  // NOTE: compare sr_next, not sr; sr lags the bit being sampled by one edge.
  assign sr_next  = {sr[6:0], data_in};
  assign is_comma = (sr_next == COMMA);

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) sr <= 8'h00;
    else          sr <= sr_next;
  end

endmodule : sp_shift_reg

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: locks byte alignment on BC_COUNT consecutive
// aligned commas, then strobes out every non-comma byte.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA    = COMMA_DEFAULT,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [7:0] sr_next;
  logic       is_comma;
  logic       boundary;
  logic [3:0] bc_inc;

  sp_shift_reg #(
    .COMMA (COMMA)
  ) u_shift (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .sr_next  (sr_next),
    .is_comma (is_comma)
  );

  assign boundary = (bit_cnt == 3'd7);
  assign bc_inc   = bc_cnt + 4'd1;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      bit_cnt   <= 3'd0;
      bc_cnt    <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      bit_cnt   <= bit_cnt + 3'd1;
      case (state)
        SEARCH: begin
          // A comma at any bit offset defines the byte phase.
          if (is_comma) begin
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
            if (BC_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_inc;
              if (bc_inc == BC_TARGET) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              bc_cnt <= 4'd0;
              state  <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // Lock is held until reset; commas are idle fill and are dropped.
          if (boundary && !is_comma) begin
            data_out  <= sr_next;
            valid_out <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_paralelo

// File: doc/serial_paralelo.md
# serial_paralelo

Serial-to-parallel receiver for the 1-bit link driven by the team's parallel-to-serial transmitter. The transmitter sends bytes MSB first at one bit per `clk_32f` cycle and inserts the comma `0xBC` when it has no valid data. This block deserializes the stream and finds byte alignment by locking onto repeated commas. Once locked, it delivers each non-comma byte as an 8-bit word with a one-cycle valid strobe.

## Interface
Parameters:
- `COMMA`, default `8'hBC`: idle/alignment symbol.
- `BC_COUNT`, default `4`: number of consecutive byte-aligned commas required to lock. Legal range is 1..15.

Ports:
- `clk_32f`, input, 1: bit clock. This is the only clock. All state changes on its rising edge.
- `reset_L`, input, 1: asynchronous, active-low reset.
- `data_in`, input, 1: serial bit stream, MSB of each byte first.
- `data_out`, output, 8: last received non-comma byte. Registered.
- `valid_out`, output, 1: one-cycle strobe marking a new byte on `data_out`. Registered.
- `active`, output, 1: high while byte alignment is locked. Registered.

## Operation
- Shift register `sr[7:0]`. Every cycle, `sr <= sr_next`, where `sr_next = {sr[6:0], data_in}`.
- Bit counter `bit_cnt[2:0]`, wraps 7→0. The boundary cycle is `bit_cnt == 7`; at that point `sr_next` holds one complete byte.
- Comma counter `bc_cnt[3:0]`.
- State machine:
  - SEARCH:
    - Each cycle, if `sr_next == COMMA`: set `bit_cnt <= 0`, `bc_cnt <= 1`.
    - On that match, go to ACTIVE if `BC_COUNT == 1`, otherwise go to ALIGN.
    - With no match, `bit_cnt` is don't-care.
  - ALIGN:
    - Only boundary cycles are evaluated; mid-byte commas are ignored.
    - At a boundary with `sr_next == COMMA`: increment `bc_cnt`. If the incremented value equals `BC_COUNT`, go to ACTIVE.
    - At a boundary with any other value: set `bc_cnt <= 0` and go to SEARCH.
  - ACTIVE:
    - At a boundary with `sr_next != COMMA`: set `data_out <= sr_next` and pulse `valid_out` for one cycle.
    - At a boundary with `sr_next == COMMA`: `valid_out` stays 0 and `data_out` holds.
    - The block stays in ACTIVE until reset; there is no loss-of-lock detection in this revision.
- `active` is registered and equals 1 exactly when the state is ACTIVE.
- Reset (`reset_L == 0`, asynchronous):
  - `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state = SEARCH.
  - `data_out = 8'h00`, `valid_out = 0`, `active = 0`.
- Reset mid-operation discards any partial byte and any lock. The block must see `BC_COUNT` fresh aligned commas before it is active again.

## Timing
- Byte latency: the last bit of a byte is sampled at clock edge k. `data_out` and `valid_out` update at that same edge k and are visible for cycle k+1.
- `valid_out` is never high on two consecutive cycles. The minimum spacing between strobes is 8 cycles.
- Lock latency: `active` rises at the edge that samples the last bit of the `BC_COUNT`-th aligned comma. No `valid_out` is produced for the commas that achieve lock.
- Overlap between the comma check and the state update at the same edge: the comparison always uses `sr_next`, never the stale `sr`.
- Reset release: the first bit is sampled at the first rising `clk_32f` edge after `reset_L` goes high.
- There is no handshake and no backpressure. The consumer must take each byte in the strobe cycle.

## Structure
- Package `serial_paralelo_pkg` contains:
  - state encoding: SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2;
  - default comma constant `8'hBC`, shared with the transmitter.
- Sub-module `sp_shift_reg` contains the shift register plus comma comparator. Its outputs are `sr_next` and `is_comma`.
- The top level holds the state machine, the counters and the output registers.

## Test plan
- Reset: hold `reset_L = 0` while driving random bits → `data_out = 8'h00`, `valid_out = 0`, `active = 0` throughout. Assert `reset_L` asynchronously between edges → outputs clear immediately.
- Lock: send 3 junk bits `101`, then 4× `0xBC` → `active` rises at the edge of the last bit of the 4th comma, with no `valid_out` pulses.
- Data: after lock, send `0xA5` then `0x3C` → `valid_out` pulses twice, exactly 8 cycles apart. `data_out = 8'hA5`, then `8'h3C`, each registered at the edge of the byte's last bit.
- Idle: in ACTIVE, send `0xBC` then `0x7E` → no strobe for the comma and `data_out` holds `8'h3C`, then a strobe with `8'h7E`. A stream of `0x5E, 0xF0` (comma pattern at a non-boundary bit offset) must not disturb alignment.
- Failed align: send 2× `0xBC` then `0x55` → return to SEARCH and `active` stays 0. Then send 4× `0xBC` → lock.
- Reset mid-ACTIVE: assert reset mid-byte → all outputs are 0 and the block is in SEARCH. After release, `0xA5` alone produces no strobe until 4 aligned commas have been received.
